// File: rtl/udma_uart_cfg_regs_v2.sv
// uDMA UART configuration registers, second generation: channel setup, UART line
// setup with busy-deferred writes, W1C error flags, saturating counters, error IRQ.
module udma_uart_cfg_regs_v2 #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int DIV_WIDTH      = 16,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [31:0]               cfg_data_i,
  input  logic [4:0]                cfg_addr_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_rwn_i,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_ready_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic                      cfg_rx_continuous_o,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_clr_o,
  input  logic                      cfg_rx_en_i,
  input  logic                      cfg_rx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
  output logic                      cfg_tx_continuous_o,
  output logic                      cfg_tx_en_o,
  output logic                      cfg_tx_clr_o,
  input  logic                      cfg_tx_en_i,
  input  logic                      cfg_tx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,
  input  logic [1:0]                status_i,
  input  logic                      err_overflow_i,
  input  logic                      err_parity_i,
  input  logic                      err_frame_i,
  output logic [DIV_WIDTH-1:0]      divider_o,
  output logic                      stop_bits_o,
  output logic                      parity_en_o,
  output logic                      en_rx_o,
  output logic                      en_tx_o,
  output logic [1:0]                num_bits_o,
  output logic                      setup_pending_o,
  output logic                      err_irq_o
);

  localparam logic [4:0] A_RX_SADDR = 5'h0, A_RX_SIZE = 5'h1, A_RX_CFG = 5'h2;
  localparam logic [4:0] A_TX_SADDR = 5'h4, A_TX_SIZE = 5'h5, A_TX_CFG = 5'h6;
  localparam logic [4:0] A_STATUS = 5'h8, A_SETUP = 5'h9, A_ERROR = 5'hA;
  localparam logic [4:0] A_IRQ_EN = 5'hB, A_ERR_CNT = 5'hC;
  localparam logic [31:0] SETUP_MASK = (((32'h1 << DIV_WIDTH) - 32'h1) << 16) | 32'h0000_030F;

  typedef enum logic {IDLE, RD_RESP} state_t;
  state_t state_q, state_d;

  logic [31:0] rdata, data_q, setup_q, shadow_q;
  logic        pending_q, wr_en, rd_en, cnt_clr, irq_q;
  logic [2:0]  evt, w1c, flags_q, flags_d, irq_en_q, irq_en_d;
  logic [2:0][ERR_CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cfg_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          if (cfg_rwn_i) state_d = RD_RESP;
          else           cfg_ready_o = 1'b1;
        end
      end
      RD_RESP: begin
        cfg_ready_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en   = (state_q == IDLE) && cfg_valid_i && !cfg_rwn_i;
  assign rd_en   = (state_q == IDLE) && cfg_valid_i && cfg_rwn_i;
  assign cnt_clr = wr_en && (cfg_addr_i == A_ERR_CNT);
  assign evt     = {err_frame_i, err_parity_i, err_overflow_i};

  // An event in the same cycle as its W1C keeps the flag set.
  always_comb begin
    w1c      = (wr_en && cfg_addr_i == A_ERROR) ? cfg_data_i[2:0] : 3'b000;
    flags_d  = (flags_q & ~w1c) | evt;
    irq_en_d = (wr_en && cfg_addr_i == A_IRQ_EN) ? cfg_data_i[2:0] : irq_en_q;
  end

  always_comb begin
    rdata = 32'h0;
    case (cfg_addr_i)
      A_RX_SADDR: rdata = 32'(cfg_rx_curr_addr_i);
      A_RX_SIZE:  rdata = 32'(cfg_rx_bytes_left_i);
      A_RX_CFG:   rdata = {26'h0, cfg_rx_pending_i, cfg_rx_en_i, 3'b000, cfg_rx_continuous_o};
      A_TX_SADDR: rdata = 32'(cfg_tx_curr_addr_i);
      A_TX_SIZE:  rdata = 32'(cfg_tx_bytes_left_i);
      A_TX_CFG:   rdata = {26'h0, cfg_tx_pending_i, cfg_tx_en_i, 3'b000, cfg_tx_continuous_o};
      A_STATUS:   rdata = {30'h0, status_i};
      A_SETUP:    rdata = pending_q ? shadow_q : setup_q;
      A_ERROR:    rdata = {29'h0, flags_q};
      A_IRQ_EN:   rdata = {29'h0, irq_en_q};
      A_ERR_CNT:  rdata = 32'(err_cnt_q);
      default:    rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q              <= '0;
      cfg_rx_startaddr_o  <= '0;
      cfg_rx_size_o       <= '0;
      cfg_rx_continuous_o <= 1'b0;
      cfg_rx_en_o         <= 1'b0;
      cfg_rx_clr_o        <= 1'b0;
      cfg_tx_startaddr_o  <= '0;
      cfg_tx_size_o       <= '0;
      cfg_tx_continuous_o <= 1'b0;
      cfg_tx_en_o         <= 1'b0;
      cfg_tx_clr_o        <= 1'b0;
      setup_q             <= '0;
      shadow_q            <= '0;
      pending_q           <= 1'b0;
      flags_q             <= '0;
      irq_en_q            <= '0;
      irq_q               <= 1'b0;
      err_cnt_q           <= '0;
    end else begin
      if (rd_en) data_q <= rdata;
      cfg_rx_en_o  <= wr_en && (cfg_addr_i == A_RX_CFG) && cfg_data_i[4];
      cfg_rx_clr_o <= wr_en && (cfg_addr_i == A_RX_CFG) && cfg_data_i[5];
      cfg_tx_en_o  <= wr_en && (cfg_addr_i == A_TX_CFG) && cfg_data_i[4];
      cfg_tx_clr_o <= wr_en && (cfg_addr_i == A_TX_CFG) && cfg_data_i[5];
      if (wr_en) begin
        case (cfg_addr_i)
          A_RX_SADDR: cfg_rx_startaddr_o  <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          A_RX_SIZE:  cfg_rx_size_o       <= cfg_data_i[TRANS_SIZE-1:0];
          A_RX_CFG:   cfg_rx_continuous_o <= cfg_data_i[0];
          A_TX_SADDR: cfg_tx_startaddr_o  <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          A_TX_SIZE:  cfg_tx_size_o       <= cfg_data_i[TRANS_SIZE-1:0];
          A_TX_CFG:   cfg_tx_continuous_o <= cfg_data_i[0];
          default: ;
        endcase
      end
      // Disabling both directions is always safe to apply at once.
      if (wr_en && cfg_addr_i == A_SETUP) begin
        if (status_i == 2'b00 || cfg_data_i[9:8] == 2'b00) begin
          setup_q   <= cfg_data_i & SETUP_MASK;
          pending_q <= 1'b0;
        end else begin
          shadow_q  <= cfg_data_i & SETUP_MASK;
          pending_q <= 1'b1;
        end
      end else if (pending_q && status_i == 2'b00) begin
        setup_q   <= shadow_q;
        pending_q <= 1'b0;
      end
      flags_q  <= flags_d;
      irq_en_q <= irq_en_d;
      irq_q    <= |(flags_d & irq_en_d);
      for (int i = 0; i < 3; i++) begin
        if (cnt_clr)
          err_cnt_q[i] <= ERR_CNT_WIDTH'(evt[i]);
        else if (evt[i] && err_cnt_q[i] != {ERR_CNT_WIDTH{1'b1}})
          err_cnt_q[i] <= err_cnt_q[i] + ERR_CNT_WIDTH'(1);
      end
    end
  end

  assign cfg_data_o      = (state_q == RD_RESP) ? data_q : 32'h0;
  assign divider_o       = setup_q[16 +: DIV_WIDTH];
  assign en_rx_o         = setup_q[9];
  assign en_tx_o         = setup_q[8];
  assign stop_bits_o     = setup_q[3];
  assign num_bits_o      = setup_q[2:1];
  assign parity_en_o     = setup_q[0];
  assign setup_pending_o = pending_q;
  assign err_irq_o       = irq_q;

endmodule

// File: tb/tb_udma_uart_cfg_regs_v2.sv
// Directed bench for udma_uart_cfg_regs_v2: setup deferral, CFG pulses, error
// flags/counters/IRQ and async reset during a read response.
module tb_udma_uart_cfg_regs_v2;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] cfg_data_i, cfg_data_o;
  logic [4:0]  cfg_addr_i;
  logic        cfg_valid_i, cfg_rwn_i, cfg_ready_o;
  logic [11:0] cfg_rx_startaddr_o, cfg_tx_startaddr_o;
  logic [15:0] cfg_rx_size_o, cfg_tx_size_o;
  logic        cfg_rx_continuous_o, cfg_tx_continuous_o;
  logic        cfg_rx_en_o, cfg_tx_en_o, cfg_rx_clr_o, cfg_tx_clr_o;
  logic        cfg_rx_en_i, cfg_tx_en_i, cfg_rx_pending_i, cfg_tx_pending_i;
  logic [11:0] cfg_rx_curr_addr_i, cfg_tx_curr_addr_i;
  logic [15:0] cfg_rx_bytes_left_i, cfg_tx_bytes_left_i;
  logic [1:0]  status_i;
  logic        err_overflow_i, err_parity_i, err_frame_i;
  logic [15:0] divider_o;
  logic        stop_bits_o, parity_en_o, en_rx_o, en_tx_o;
  logic [1:0]  num_bits_o;
  logic        setup_pending_o, err_irq_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd;

  always #5 clk_i = ~clk_i;

  udma_uart_cfg_regs_v2 dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
    .cfg_rwn_i(cfg_rwn_i), .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
    .cfg_rx_startaddr_o(cfg_rx_startaddr_o), .cfg_rx_size_o(cfg_rx_size_o),
    .cfg_rx_continuous_o(cfg_rx_continuous_o), .cfg_rx_en_o(cfg_rx_en_o),
    .cfg_rx_clr_o(cfg_rx_clr_o), .cfg_rx_en_i(cfg_rx_en_i),
    .cfg_rx_pending_i(cfg_rx_pending_i), .cfg_rx_curr_addr_i(cfg_rx_curr_addr_i),
    .cfg_rx_bytes_left_i(cfg_rx_bytes_left_i),
    .cfg_tx_startaddr_o(cfg_tx_startaddr_o), .cfg_tx_size_o(cfg_tx_size_o),
    .cfg_tx_continuous_o(cfg_tx_continuous_o), .cfg_tx_en_o(cfg_tx_en_o),
    .cfg_tx_clr_o(cfg_tx_clr_o), .cfg_tx_en_i(cfg_tx_en_i),
    .cfg_tx_pending_i(cfg_tx_pending_i), .cfg_tx_curr_addr_i(cfg_tx_curr_addr_i),
    .cfg_tx_bytes_left_i(cfg_tx_bytes_left_i),
    .status_i(status_i), .err_overflow_i(err_overflow_i), .err_parity_i(err_parity_i),
    .err_frame_i(err_frame_i), .divider_o(divider_o), .stop_bits_o(stop_bits_o),
    .parity_en_o(parity_en_o), .en_rx_o(en_rx_o), .en_tx_o(en_tx_o),
    .num_bits_o(num_bits_o), .setup_pending_o(setup_pending_o), .err_irq_o(err_irq_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_addr_i = a; cfg_data_i = d; cfg_rwn_i = 1'b0; cfg_valid_i = 1'b1;
    #1 check("wr_ready", cfg_ready_o, 1);
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
    cfg_addr_i = a; cfg_rwn_i = 1'b1; cfg_valid_i = 1'b1;
    #1 check("rd_req_ready", cfg_ready_o, 0);
    @(posedge clk_i); #1;
    check("rd_resp_ready", cfg_ready_o, 1);
    d = cfg_data_o;
    cfg_valid_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  initial begin
    rstn_i = 1'b0; cfg_data_i = '0; cfg_addr_i = '0; cfg_valid_i = 1'b0; cfg_rwn_i = 1'b0;
    cfg_rx_en_i = 1'b0; cfg_tx_en_i = 1'b0; cfg_rx_pending_i = 1'b0; cfg_tx_pending_i = 1'b0;
    cfg_rx_curr_addr_i = '0; cfg_tx_curr_addr_i = '0;
    cfg_rx_bytes_left_i = '0; cfg_tx_bytes_left_i = '0;
    status_i = 2'b00; err_overflow_i = 1'b0; err_parity_i = 1'b0; err_frame_i = 1'b0;
    #2;
    check("rst_ready", cfg_ready_o, 0);
    check("rst_data", cfg_data_o, 0);
    check("rst_div", divider_o, 0);
    check("rst_pending", setup_pending_o, 0);
    check("rst_irq", err_irq_o, 0);
    tick(); tick();
    rstn_i = 1'b1;
    tick();

    // immediate setup
    cfg_write(5'h9, 32'h01B7_030D);
    check("setup_div", divider_o, 32'h01B7);
    check("setup_ens", {en_rx_o, en_tx_o}, 2'b11);
    check("setup_stop", stop_bits_o, 1);
    check("setup_nbits", num_bits_o, 2'b10);
    check("setup_par", parity_en_o, 1);
    cfg_read(5'h9, rd);
    check("setup_rd", rd, 32'h01B7_030D);

    // deferred setup
    status_i = 2'b01;
    cfg_write(5'h9, 32'h0100_0306);
    check("defer_pending", setup_pending_o, 1);
    check("defer_div_hold", divider_o, 32'h01B7);
    check("defer_par_hold", parity_en_o, 1);
    cfg_read(5'h9, rd);
    check("defer_rd_shadow", rd, 32'h0100_0306);
    status_i = 2'b00;
    tick();
    check("apply_div", divider_o, 32'h0100);
    check("apply_pending", setup_pending_o, 0);
    check("apply_nbits", num_bits_o, 2'b11);
    check("apply_par", parity_en_o, 0);
    status_i = 2'b01;
    cfg_write(5'h9, 32'h0100_0306);
    check("defer2_pending", setup_pending_o, 1);
    cfg_write(5'h9, 32'h0);
    check("disable_ens", {en_rx_o, en_tx_o}, 2'b00);
    check("disable_pending", setup_pending_o, 0);
    check("disable_div", divider_o, 0);
    status_i = 2'b00;

    // channel cfg pulses
    cfg_write(5'h2, 32'h31);
    check("rx_en_pulse", cfg_rx_en_o, 1);
    check("rx_clr_pulse", cfg_rx_clr_o, 1);
    tick();
    check("rx_en_end", cfg_rx_en_o, 0);
    check("rx_clr_end", cfg_rx_clr_o, 0);
    check("rx_cont", cfg_rx_continuous_o, 1);
    cfg_write(5'h6, 32'h00);
    check("tx_no_pulse", {cfg_tx_en_o, cfg_tx_clr_o}, 2'b00);
    cfg_rx_en_i = 1'b1; cfg_rx_pending_i = 1'b1;
    cfg_read(5'h2, rd);
    check("rx_cfg_rd", rd, 32'h31);
    cfg_rx_en_i = 1'b0; cfg_rx_pending_i = 1'b0;

    // parity errors, irq, W1C
    cfg_write(5'hB, 32'h2);
    for (int i = 0; i < 3; i++) begin
      err_parity_i = 1'b1; tick();
      err_parity_i = 1'b0; tick();
    end
    cfg_read(5'hA, rd);
    check("err_flags", rd, 32'h2);
    cfg_read(5'hC, rd);
    check("err_cnt_par3", rd, 32'h0000_0300);
    check("irq_par", err_irq_o, 1);
    cfg_read(5'hA, rd);
    check("err_rd_no_side", rd, 32'h2);
    err_parity_i = 1'b1;
    cfg_write(5'hA, 32'h2);
    err_parity_i = 1'b0;
    check("w1c_set_wins_irq", err_irq_o, 1);
    cfg_read(5'hA, rd);
    check("w1c_set_wins", rd, 32'h2);
    cfg_write(5'hA, 32'h2);
    check("w1c_irq_drop", err_irq_o, 0);
    cfg_read(5'hA, rd);
    check("w1c_clear", rd, 32'h0);

    // frame counter saturation and clear-with-event
    err_frame_i = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    err_frame_i = 1'b0;
    cfg_read(5'hC, rd);
    check("cnt_sat", rd, 32'h00FF_0400);
    check("irq_masked", err_irq_o, 0);
    err_frame_i = 1'b1;
    cfg_write(5'hC, 32'h0);
    err_frame_i = 1'b0;
    cfg_read(5'hC, rd);
    check("cnt_clr_evt", rd, 32'h0001_0000);
    cfg_write(5'hB, 32'h4);
    check("irq_frame", err_irq_o, 1);

    // status and unmapped
    status_i = 2'b10;
    cfg_read(5'h8, rd);
    check("status_rd", rd, 32'h2);
    status_i = 2'b00;
    cfg_read(5'hD, rd);
    check("unmapped_rd", rd, 32'h0);

    // async reset in RD_RESP with a pending setup
    cfg_write(5'h9, 32'h01B7_030D);
    status_i = 2'b01;
    cfg_write(5'h9, 32'h0100_0306);
    cfg_addr_i = 5'h9; cfg_rwn_i = 1'b1; cfg_valid_i = 1'b1;
    tick();
    check("pre_rst_ready", cfg_ready_o, 1);
    rstn_i = 1'b0;
    #1;
    check("rst_mid_ready", cfg_ready_o, 0);
    check("rst_mid_data", cfg_data_o, 0);
    check("rst_mid_pending", setup_pending_o, 0);
    check("rst_mid_div", divider_o, 0);
    check("rst_mid_en", {en_rx_o, en_tx_o}, 2'b00);
    check("rst_mid_cont", cfg_rx_continuous_o, 0);
    check("rst_mid_irq", err_irq_o, 0);
    cfg_valid_i = 1'b0; status_i = 2'b00;
    tick();
    rstn_i = 1'b1;
    tick();
    cfg_read(5'h9, rd);
    check("post_rst_setup", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/udma_uart_cfg_regs_v2.md
Name: udma_uart_cfg_regs_v2

Overview:
- Second-generation uDMA UART configuration register block: RX/TX channel config, UART line setup and error reporting.
- Sits between the uDMA APB-side cfg bus and one UART core plus its RX/TX uDMA channels.
- New versus v1:
  - parametrised divider width
  - frame-error source
  - write-1-to-clear error flags (no read side effects)
  - saturating error counters and a maskable error interrupt
  - registered read response
  - setup writes deferred while the UART is busy

Parameters:
- L2_AWIDTH_NOAL, 12, L2 address width of the channel start/current address.
- TRANS_SIZE, 16, transfer size / bytes-left width.
- DIV_WIDTH, 16, baud divider width; legal range 1..16.
- ERR_CNT_WIDTH, 8, width of each error counter; legal range 1..10.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_data_i  in  32  write data
- cfg_addr_i  in  5  word address
- cfg_valid_i  in  1  request valid; master holds it until cfg_ready_o
- cfg_rwn_i  in  1  1=read, 0=write
- cfg_data_o  out  32  read data, valid while cfg_ready_o=1 on a read
- cfg_ready_o  out  1  request accepted/completed
- cfg_rx_startaddr_o / cfg_tx_startaddr_o  out  L2_AWIDTH_NOAL  channel start address
- cfg_rx_size_o / cfg_tx_size_o  out  TRANS_SIZE  channel size
- cfg_rx_continuous_o / cfg_tx_continuous_o  out  1  continuous mode
- cfg_rx_en_o / cfg_tx_en_o, cfg_rx_clr_o / cfg_tx_clr_o  out  1  one-cycle pulses
- cfg_rx_en_i / cfg_tx_en_i, cfg_rx_pending_i / cfg_tx_pending_i  in  1  channel status
- cfg_rx_curr_addr_i / cfg_tx_curr_addr_i  in  L2_AWIDTH_NOAL  current address
- cfg_rx_bytes_left_i / cfg_tx_bytes_left_i  in  TRANS_SIZE  bytes left
- status_i  in  2  bit0 TX busy, bit1 RX busy
- err_overflow_i, err_parity_i, err_frame_i  in  1  one-cycle error events
- divider_o  out  DIV_WIDTH  baud divider
- stop_bits_o, parity_en_o, en_rx_o, en_tx_o  out  1  line setup
- num_bits_o  out  2  character length code
- setup_pending_o  out  1  deferred setup waiting for idle
- err_irq_o  out  1  level error interrupt

Behaviour:
- Reset: every register, output, flag and counter is 0; FSM in IDLE.
- Register map, word address:
  - 0x0–0x7: RX/TX SADDR, SIZE, CFG, INTCFG. CFG bit5 = clr pulse, bit4 = en pulse, bit0 = continuous. CFG read returns {pending, en, 3'b0, continuous} in bits [5:0]. INTCFG reads 0.
  - 0x8: STATUS, read-only, {30'b0, status_i}.
  - 0x9: SETUP. divider in [16+DIV_WIDTH-1:16], en_rx [9], en_tx [8], stop_bits [3], num_bits [2:1], parity_en [0].
  - 0xA: ERROR flags {frame[2], parity[1], overflow[0]}. Writing 1 to a bit clears that flag.
  - 0xB: IRQ_EN, bits [2:0], same bit order as ERROR.
  - 0xC: ERR_CNT, read {frame, parity, overflow} counters packed LSB-first, each ERR_CNT_WIDTH bits, zero-padded. Any write clears all three.
  - Unmapped addresses: reads return 0, writes are ignored.
- Handshake FSM, states IDLE and RD_RESP:
  - IDLE, write request: cfg_ready_o=1 combinationally in the same cycle; the register updates at the next clock edge.
  - IDLE, read request: cfg_ready_o=0; read data is captured into the output register; go to RD_RESP.
  - RD_RESP: cfg_ready_o=1 with the registered data; return to IDLE unconditionally. No new request is accepted in this cycle.
  - Read latency is 1 cycle; a back-to-back read completes every 2 cycles.
  - cfg_data_o is 0 whenever not in RD_RESP.
- en/clr pulses: high for exactly one cycle after the accepting edge, then 0. Writing 0 to those bits produces no pulse.
- SETUP deferral:
  - status_i==0 at the accepting cycle: the write applies at that edge.
  - status_i!=0: the value is stored in a shadow register and setup_pending_o=1. It applies at the first edge with status_i==0, and setup_pending_o clears at that edge.
  - A further write while pending overwrites the shadow.
  - A write with en_rx=en_tx=0 always applies immediately and cancels any pending value.
  - A SETUP read returns the shadow when pending, otherwise the live value.
- Error flags:
  - Set on an event.
  - Set wins over a W1C in the same cycle.
  - Reads have no side effects.
- Error counters:
  - +1 per event cycle.
  - Saturate at all-ones.
  - Clear and event in the same cycle gives 1.
- err_irq_o = |(flags & irq_en), driven from registers, glitch-free.
- Async reset mid-transaction returns the FSM to IDLE and drops any pending setup.

Test Plan:
- Write SETUP 0x01B7_030D with status_i=0:
  - divider_o=0x01B7, en_rx=en_tx=1, stop_bits=1, num_bits=2'b10, parity_en=1 after one edge.
  - A following read returns the same value with cfg_ready_o high exactly 1 cycle after the request.
- With status_i=2'b01, write SETUP 0x0100_0306:
  - setup_pending_o=1 and outputs unchanged; a read returns the shadow.
  - Drop status_i to 0: outputs update on that edge and setup_pending_o=0.
  - Repeat, then write 0x0 while busy: en_tx_o=en_rx_o=0 on the next edge and pending is cleared.
- Write RX_CFG 0x31:
  - cfg_rx_clr_o and cfg_rx_en_o pulse for one cycle; cfg_rx_continuous_o=1 stays.
  - A TX_CFG write of 0x00 produces no pulses.
- Pulse err_parity_i three times with IRQ_EN=0x2:
  - ERROR reads 0x2, ERR_CNT parity field =3, err_irq_o=1.
  - A read leaves the flag set.
  - W1C 0x2 in the same cycle as a new err_parity_i leaves the flag set; a W1C alone clears it and err_irq_o drops.
- Pulse err_frame_i 300 times with ERR_CNT_WIDTH=8: frame count saturates at 0xFF. A write to ERR_CNT concurrent with an event yields 1.
- Assert rstn_i low in RD_RESP with a setup pending: all outputs go to 0 immediately and cfg_ready_o=0.
